// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - MSB-first serial pattern transmitter with aligned expected-detection pulse
// Optional inter-frame gap state compiled in with SEQ_GEN_GAP_EN.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] rep_count,
  input  logic             overlap,
  input  logic [GAP_W-1:0] gap_len,
  output logic             busy,
  output logic             data_out,
  output logic             bit_valid,
  output logic             frame_end,
  output logic             expect_det,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_W - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef SEQ_GEN_GAP_EN
    ST_GAP   = 2'd3,
`endif
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;

  logic busy_d, data_out_d, bit_valid_d, frame_end_d, done_d;

`ifdef SEQ_GEN_GAP_EN
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  logic unused_gap;
  assign unused_gap = ^gap_len;
`endif

  // Outputs are registered from the next-state values, so each output
  // register reflects the state the FSM occupies during the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      reps_q     <= '0;
      pat_q      <= '0;
      ovl_q      <= 1'b0;
      busy       <= 1'b0;
      data_out   <= 1'b0;
      bit_valid  <= 1'b0;
      frame_end  <= 1'b0;
      expect_det <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_q      <= '0;
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      reps_q     <= reps_d;
      pat_q      <= pat_d;
      ovl_q      <= ovl_d;
      busy       <= busy_d;
      data_out   <= data_out_d;
      bit_valid  <= bit_valid_d;
      frame_end  <= frame_end_d;
      expect_det <= frame_end;
      done       <= done_d;
`ifdef SEQ_GEN_GAP_EN
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    reps_d  = reps_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
`ifdef SEQ_GEN_GAP_EN
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d  = pattern;
          ovl_d  = overlap;
          reps_d = rep_count;
          idx_d  = IDX_TOP;
`ifdef SEQ_GEN_GAP_EN
          gap_d  = gap_len;
`endif
          state_d = (rep_count == '0) ? ST_DONE : ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (idx_q == '0) begin
          reps_d = reps_q - CNT_W'(1);
          if (reps_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
`ifdef SEQ_GEN_GAP_EN
          else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
          end
`endif
          // Matching end bits let the next frame reuse the bit just sent.
          else if (ovl_q && (pat_q[PAT_W-1] == pat_q[0])) begin
            idx_d = IDX_OVL;
          end else begin
            idx_d = IDX_TOP;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

`ifdef SEQ_GEN_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = ST_SHIFT;
          idx_d   = IDX_TOP;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bit_valid_d = (state_d == ST_SHIFT);
    data_out_d  = bit_valid_d & pat_d[idx_d];
    frame_end_d = bit_valid_d && (idx_d == '0);
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed per-cycle vector bench for seq_pattern_gen
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = 4'b0;
  logic [7:0] rep_count = 8'd0;
  logic       overlap = 1'b0;
  logic [3:0] gap_len = 4'd0;
  logic       busy, data_out, bit_valid, frame_end, expect_det, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .rep_count  (rep_count),
    .overlap    (overlap),
    .gap_len    (gap_len),
    .busy       (busy),
    .data_out   (data_out),
    .bit_valid  (bit_valid),
    .frame_end  (frame_end),
    .expect_det (expect_det),
    .done       (done)
  );

  // One record per clock edge: inputs sampled at that edge, expected
  // outputs {busy,data_out,bit_valid,frame_end,expect_det,done} in the following cycle.
  typedef struct {
    logic       r;
    logic       s;
    logic [3:0] p;
    logic [7:0] rc;
    logic       o;
    logic [3:0] g;
    logic [5:0] e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [3:0] p,
                     input logic [7:0] rc, input logic o, input logic [3:0] g,
                     input logic [5:0] e);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.rc = rc; v.o = o; v.g = g; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [5:0] e);
    add(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 4'd0, e);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  initial begin
    logic [5:0] got;
    int n_v, n_1, n_fe, n_ed, n_bad, seen_done;

    // reset
    add(1'b1, 1'b0, 4'b0000, 8'd0, 1'b0, 4'd0, 6'b000000);
    add(1'b1, 1'b1, 4'b1111, 8'd3, 1'b0, 4'd0, 6'b000000);
    idle(6'b000000);

    // 1001, rep 1, no overlap
    add(1'b0, 1'b1, 4'b1001, 8'd1, 1'b0, 4'd0, 6'b111000);
    idle(6'b101000); idle(6'b101000); idle(6'b111100);
    idle(6'b100011); idle(6'b000000);

    // 1001, rep 3, overlap: 1001 001 001
    add(1'b0, 1'b1, 4'b1001, 8'd3, 1'b1, 4'd0, 6'b111000);
    idle(6'b101000); idle(6'b101000); idle(6'b111100);
    idle(6'b101010); idle(6'b101000); idle(6'b111100);
    idle(6'b101010); idle(6'b101000); idle(6'b111100);
    idle(6'b100011); idle(6'b000000);

    // 1010, rep 2, overlap requested but end bits differ
    add(1'b0, 1'b1, 4'b1010, 8'd2, 1'b1, 4'd0, 6'b111000);
    idle(6'b101000); idle(6'b111000); idle(6'b101100);
    idle(6'b111010); idle(6'b101000); idle(6'b111000); idle(6'b101100);
    idle(6'b100011); idle(6'b000000);

    // rep 0: done next cycle, restart in done cycle ignored, accepted one later
    add(1'b0, 1'b1, 4'b1001, 8'd0, 1'b0, 4'd0, 6'b100001);
    add(1'b0, 1'b1, 4'b1100, 8'd1, 1'b0, 4'd0, 6'b000000);
    add(1'b0, 1'b1, 4'b1100, 8'd1, 1'b0, 4'd0, 6'b111000);
    idle(6'b111000); idle(6'b101000); idle(6'b101100);
    idle(6'b100011); idle(6'b000000);

    // 1001 rep 3, inputs toggled mid-transfer, reset during bit 3 of frame 2
    add(1'b0, 1'b1, 4'b1001, 8'd3, 1'b0, 4'd0, 6'b111000);
    add(1'b0, 1'b1, 4'b0110, 8'd1, 1'b1, 4'd0, 6'b101000);
    add(1'b0, 1'b0, 4'b1111, 8'd0, 1'b0, 4'd0, 6'b101000);
    add(1'b0, 1'b1, 4'b0000, 8'd5, 1'b1, 4'd0, 6'b111100);
    add(1'b0, 1'b0, 4'b0000, 8'd0, 1'b0, 4'd0, 6'b111010);
    add(1'b0, 1'b1, 4'b0110, 8'd2, 1'b0, 4'd0, 6'b101000);
    idle(6'b101000);
    add(1'b1, 1'b0, 4'b0000, 8'd0, 1'b0, 4'd0, 6'b000000);
    idle(6'b000000);
    add(1'b0, 1'b1, 4'b1010, 8'd1, 1'b0, 4'd0, 6'b111000);
    idle(6'b101000); idle(6'b111000); idle(6'b101100);
    idle(6'b100011); idle(6'b000000);

    // 1001 rep 2 overlap with gap_len=2
    add(1'b0, 1'b1, 4'b1001, 8'd2, 1'b1, 4'd2, 6'b111000);
    idle(6'b101000); idle(6'b101000); idle(6'b111100);
`ifdef SEQ_GEN_GAP_EN
    idle(6'b100010); idle(6'b100000);
    idle(6'b111000); idle(6'b101000); idle(6'b101000); idle(6'b111100);
    idle(6'b100011); idle(6'b000000);
`else
    idle(6'b101010); idle(6'b101000); idle(6'b111100);
    idle(6'b100011); idle(6'b000000);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].r;
      start     = vecs[i].s;
      pattern   = vecs[i].p;
      rep_count = vecs[i].rc;
      overlap   = vecs[i].o;
      gap_len   = vecs[i].g;
      @(posedge clk);
      #1;
      got = {busy, data_out, bit_valid, frame_end, expect_det, done};
      checks++;
      if (got !== vecs[i].e) begin
        failures++;
        $display("FAIL vec[%0d] got=%b expected=%b (busy,dout,valid,fend,edet,done)",
                 i, got, vecs[i].e);
      end
    end

    // Maximum repetition count: 255 frames of 1011, no wrap of the frame counter
    rst = 1'b0; start = 1'b1; pattern = 4'b1011; rep_count = 8'd255;
    overlap = 1'b0; gap_len = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0; pattern = 4'b0000; rep_count = 8'd0;
    n_v = 0; n_1 = 0; n_fe = 0; n_ed = 0; n_bad = 0; seen_done = 0;
    for (int c = 0; c < 2000 && seen_done == 0; c++) begin
      if (bit_valid) n_v++;
      if (data_out) n_1++;
      if (!bit_valid && data_out) n_bad++;
      if (frame_end) n_fe++;
      if (expect_det) n_ed++;
      if (done) seen_done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("max_rep_done_seen", seen_done, 1);
    check("max_rep_valid_bits", n_v, 1020);
    check("max_rep_one_bits", n_1, 765);
    check("max_rep_frame_end", n_fe, 255);
    check("max_rep_expect_det", n_ed, 255);
    check("max_rep_data_without_valid", n_bad, 0);
    @(posedge clk);
    #1;
    check("max_rep_busy_after", int'(busy), 0);
    check("max_rep_done_after", int'(done), 0);

    // Overlap with pattern 0110 (end bits 0): 0110 then 110, 7 valid bits
    start = 1'b1; pattern = 4'b0110; rep_count = 8'd2; overlap = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_v = 0; n_1 = 0; n_fe = 0; seen_done = 0;
    for (int c = 0; c < 50 && seen_done == 0; c++) begin
      if (bit_valid) n_v++;
      if (data_out) n_1++;
      if (frame_end) n_fe++;
      if (done) seen_done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("ovl0110_done_seen", seen_done, 1);
    check("ovl0110_valid_bits", n_v, 7);
    check("ovl0110_one_bits", n_1, 4);
    check("ovl0110_frame_end", n_fe, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
